// File: rtl/mips_bus_if.sv
// Shared Avalon-style memory bus between the CPU (master) and memory (slave).
// One bus carries both instruction fetches and data accesses.
interface mips_bus_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_core.sv
// Multicycle MIPS-I subset CPU on a single shared memory bus, with branch delay slots.
// Execution halts when the program transfers control to address 0.
module mips_bus_core (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  mips_bus_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  state_t      state_r, state_n;
  logic [31:0] pc_r, pc_n;
  logic [31:0] npc_r, npc_n;
  logic [31:0] ir_r, ir_n;
  logic [1:0]  ea_lo_r, ea_lo_n;
  logic [31:0] address_r, address_n;
  logic        read_r, read_n;
  logic        write_r, write_n;
  logic [31:0] writedata_r, writedata_n;
  logic [3:0]  byteenable_r, byteenable_n;
  logic        active_r, active_n;
  logic [31:0] gpr_r [0:31];

  // The instruction sits on readdata during EXEC and in IR afterwards.
  logic [31:0] instr_s;
  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic [15:0] imm_s;
  logic [31:0] rs_val_s, rt_val_s, simm_s, zimm_s;
  logic [31:0] pc_plus4_s, link_s, branch_target_s, jump_target_s, ea_s;

  assign instr_s         = (state_r == S_EXEC) ? bus.readdata : ir_r;
  assign op_s            = instr_s[31:26];
  assign rs_s            = instr_s[25:21];
  assign rt_s            = instr_s[20:16];
  assign rd_s            = instr_s[15:11];
  assign shamt_s         = instr_s[10:6];
  assign funct_s         = instr_s[5:0];
  assign imm_s           = instr_s[15:0];
  assign rs_val_s        = gpr_r[rs_s];
  assign rt_val_s        = gpr_r[rt_s];
  assign simm_s          = {{16{imm_s[15]}}, imm_s};
  assign zimm_s          = {16'd0, imm_s};
  assign pc_plus4_s      = pc_r + 32'd4;
  assign link_s          = pc_r + 32'd8;
  assign branch_target_s = pc_plus4_s + {simm_s[29:0], 2'b00};
  assign jump_target_s   = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
  assign ea_s            = rs_val_s + simm_s;

  assign bus.address    = address_r;
  assign bus.read       = read_r;
  assign bus.write      = write_r;
  assign bus.writedata  = writedata_r;
  assign bus.byteenable = byteenable_r;
  assign active         = active_r;
  assign register_v0    = gpr_r[2];

  logic        exec_wb_en_s;
  logic [4:0]  exec_wb_addr_s;
  logic [31:0] exec_result_s;
  logic        taken_s;
  logic [31:0] target_s;
  logic        is_load_s, is_store_s;

  // Decode and execute the instruction presented in EXEC.
  always_comb begin
    exec_wb_en_s   = 1'b0;
    exec_wb_addr_s = rd_s;
    exec_result_s  = 32'd0;
    taken_s        = 1'b0;
    target_s       = branch_target_s;
    is_load_s      = 1'b0;
    is_store_s     = 1'b0;
    case (op_s)
      6'h00: begin
        exec_wb_en_s = 1'b1;
        case (funct_s)
          6'h00: exec_result_s = rt_val_s << shamt_s;
          6'h02: exec_result_s = rt_val_s >> shamt_s;
          6'h03: exec_result_s = 32'($signed(rt_val_s) >>> shamt_s);
          6'h04: exec_result_s = rt_val_s << rs_val_s[4:0];
          6'h06: exec_result_s = rt_val_s >> rs_val_s[4:0];
          6'h07: exec_result_s = 32'($signed(rt_val_s) >>> rs_val_s[4:0]);
          6'h08: begin
            exec_wb_en_s = 1'b0;
            taken_s      = 1'b1;
            target_s     = rs_val_s;
          end
          6'h09: begin
            taken_s       = 1'b1;
            target_s      = rs_val_s;
            exec_result_s = link_s;
          end
          6'h21: exec_result_s = rs_val_s + rt_val_s;
          6'h23: exec_result_s = rs_val_s - rt_val_s;
          6'h24: exec_result_s = rs_val_s & rt_val_s;
          6'h25: exec_result_s = rs_val_s | rt_val_s;
          6'h26: exec_result_s = rs_val_s ^ rt_val_s;
          6'h2A: exec_result_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)};
          6'h2B: exec_result_s = {31'd0, rs_val_s < rt_val_s};
          default: exec_wb_en_s = 1'b0;
        endcase
      end
      6'h01: begin
        case (rt_s)
          5'h00:   taken_s = rs_val_s[31];
          5'h01:   taken_s = ~rs_val_s[31];
          default: taken_s = 1'b0;
        endcase
      end
      6'h02: begin
        taken_s  = 1'b1;
        target_s = jump_target_s;
      end
      6'h03: begin
        taken_s        = 1'b1;
        target_s       = jump_target_s;
        exec_wb_en_s   = 1'b1;
        exec_wb_addr_s = 5'd31;
        exec_result_s  = link_s;
      end
      6'h04: taken_s = (rs_val_s == rt_val_s);
      6'h05: taken_s = (rs_val_s != rt_val_s);
      6'h06: taken_s = rs_val_s[31] | (rs_val_s == 32'd0);
      6'h07: taken_s = ~rs_val_s[31] & (rs_val_s != 32'd0);
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        exec_wb_en_s   = 1'b1;
        exec_wb_addr_s = rt_s;
        case (op_s)
          6'h09:   exec_result_s = rs_val_s + simm_s;
          6'h0A:   exec_result_s = {31'd0, $signed(rs_val_s) < $signed(simm_s)};
          6'h0B:   exec_result_s = {31'd0, rs_val_s < simm_s};
          6'h0C:   exec_result_s = rs_val_s & zimm_s;
          6'h0D:   exec_result_s = rs_val_s | zimm_s;
          6'h0E:   exec_result_s = rs_val_s ^ zimm_s;
          default: exec_result_s = {imm_s, 16'd0};
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load_s  = 1'b1;
      6'h28, 6'h29, 6'h2B:               is_store_s = 1'b1;
      default: exec_wb_en_s = 1'b0;
    endcase
  end

  logic [31:0] store_data_s;
  logic [3:0]  store_be_s;

  // Replicate sub-word store data across lanes and pick the lane enables.
  always_comb begin
    store_data_s = rt_val_s;
    store_be_s   = 4'hF;
    case (op_s[1:0])
      2'b00: begin
        store_data_s = {4{rt_val_s[7:0]}};
        store_be_s   = 4'b0001 << ea_s[1:0];
      end
      2'b01: begin
        store_data_s = {2{rt_val_s[15:0]}};
        store_be_s   = ea_s[1] ? 4'hC : 4'h3;
      end
      default: begin
        store_data_s = rt_val_s;
        store_be_s   = 4'hF;
      end
    endcase
  end

  logic [7:0]  load_byte_s;
  logic [15:0] load_half_s;
  logic [31:0] load_data_s;

  // Select and extend the addressed lane(s) of returned load data.
  always_comb begin
    case (ea_lo_r)
      2'd0:    load_byte_s = bus.readdata[7:0];
      2'd1:    load_byte_s = bus.readdata[15:8];
      2'd2:    load_byte_s = bus.readdata[23:16];
      default: load_byte_s = bus.readdata[31:24];
    endcase
    load_half_s = ea_lo_r[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    case (op_s)
      6'h20:   load_data_s = {{24{load_byte_s[7]}}, load_byte_s};
      6'h24:   load_data_s = {24'd0, load_byte_s};
      6'h21:   load_data_s = {{16{load_half_s[15]}}, load_half_s};
      6'h25:   load_data_s = {16'd0, load_half_s};
      default: load_data_s = bus.readdata;
    endcase
  end

  logic        wb_en_s;
  logic [4:0]  wb_addr_s;
  logic [31:0] wb_data_s;
  logic [31:0] resume_pc_s;

  // Next-state, bus request and writeback selection.
  always_comb begin
    state_n      = state_r;
    pc_n         = pc_r;
    npc_n        = npc_r;
    ir_n         = ir_r;
    ea_lo_n      = ea_lo_r;
    address_n    = address_r;
    read_n       = read_r;
    write_n      = write_r;
    writedata_n  = writedata_r;
    byteenable_n = byteenable_r;
    active_n     = active_r;
    wb_en_s      = 1'b0;
    wb_addr_s    = 5'd0;
    wb_data_s    = 32'd0;
    resume_pc_s  = pc_r;
    case (state_r)
      S_FETCH: begin
        if (read_r && !bus.waitrequest) begin
          state_n = S_EXEC;
          read_n  = 1'b0;
        end else begin
          read_n       = 1'b1;
          address_n    = pc_r;
          byteenable_n = 4'hF;
        end
      end
      S_EXEC: begin
        ir_n      = bus.readdata;
        pc_n      = npc_r;
        npc_n     = taken_s ? target_s : npc_r + 32'd4;
        wb_en_s   = exec_wb_en_s;
        wb_addr_s = exec_wb_addr_s;
        wb_data_s = exec_result_s;
        if (is_load_s || is_store_s) begin
          state_n      = S_MEM;
          ea_lo_n      = ea_s[1:0];
          address_n    = {ea_s[31:2], 2'b00};
          read_n       = is_load_s;
          write_n      = is_store_s;
          writedata_n  = store_data_s;
          byteenable_n = is_store_s ? store_be_s : 4'hF;
        end else begin
          resume_pc_s = npc_r;
          state_n     = S_FETCH;
        end
      end
      S_MEM: begin
        if (!bus.waitrequest) begin
          read_n  = 1'b0;
          write_n = 1'b0;
          state_n = read_r ? S_WB : S_FETCH;
        end else begin
          state_n = S_MEM;
        end
      end
      S_WB: begin
        wb_en_s   = 1'b1;
        wb_addr_s = rt_s;
        wb_data_s = load_data_s;
        state_n   = S_FETCH;
      end
      S_HALTED: begin
        active_n = 1'b0;
        read_n   = 1'b0;
        write_n  = 1'b0;
      end
      default: state_n = S_HALTED;
    endcase

    // Every return to FETCH checks for the halt address first.
    if (state_n == S_FETCH && state_r != S_FETCH) begin
      if (resume_pc_s == 32'd0) begin
        state_n  = S_HALTED;
        active_n = 1'b0;
        read_n   = 1'b0;
        write_n  = 1'b0;
      end else begin
        read_n       = 1'b1;
        write_n      = 1'b0;
        address_n    = resume_pc_s;
        byteenable_n = 4'hF;
      end
    end else begin
      active_n = active_n;
    end
  end

  // Control and bus output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_FETCH;
      pc_r         <= RESET_VECTOR;
      npc_r        <= RESET_VECTOR + 32'd4;
      ir_r         <= 32'd0;
      ea_lo_r      <= 2'd0;
      address_r    <= RESET_VECTOR;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      writedata_r  <= 32'd0;
      byteenable_r <= 4'hF;
      active_r     <= 1'b1;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      npc_r        <= npc_n;
      ir_r         <= ir_n;
      ea_lo_r      <= ea_lo_n;
      address_r    <= address_n;
      read_r       <= read_n;
      write_r      <= write_n;
      writedata_r  <= writedata_n;
      byteenable_r <= byteenable_n;
      active_r     <= active_n;
    end
  end

  // Register file; $0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_r[i] <= 32'd0;
      end
    end else if (wb_en_s && (wb_addr_s != 5'd0)) begin
      gpr_r[wb_addr_s] <= wb_data_s;
    end else begin
      gpr_r[0] <= 32'd0;
    end
  end

endmodule

// File: tb/tb_mips_bus_core.sv
// Directed bench for mips_bus_core: small programs run from a memory model,
// results observed through register_v0, active and the bus.
module tb_mips_bus_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;

  mips_bus_if bus ();

  mips_bus_core dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory model: code at 0xBFC00000 (rom), data at 0x00000000 (ram).
  logic [31:0] rom      [0:127];
  logic [31:0] ram      [0:127];
  logic [31:0] ram_init [0:127];
  logic        stall_mode = 1'b0;
  int          stall_cnt = 0;
  int          stall_seen = 0;
  int          stable_err = 0;
  logic        held = 1'b0;
  logic [31:0] held_addr, held_wd;
  logic        held_rd, held_wr;
  logic [3:0]  held_be;
  logic [3:0]  sub_be = 4'h0;

  assign bus.waitrequest = stall_mode && (stall_cnt != 0);

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) ram[i] <= ram_init[i];
      held <= 1'b0;
    end else if (bus.read || bus.write) begin
      if (held && (bus.address !== held_addr || bus.read !== held_rd || bus.write !== held_wr ||
                   bus.writedata !== held_wd || bus.byteenable !== held_be))
        stable_err <= stable_err + 1;
      if (bus.waitrequest) begin
        stall_cnt  <= stall_cnt - 1;
        stall_seen <= stall_seen + 1;
        held       <= 1'b1;
        held_addr  <= bus.address;
        held_rd    <= bus.read;
        held_wr    <= bus.write;
        held_wd    <= bus.writedata;
        held_be    <= bus.byteenable;
      end else begin
        held      <= 1'b0;
        stall_cnt <= $urandom_range(6, 1);
        if (bus.read)
          bus.readdata <= bus.address[31] ? rom[bus.address[8:2]] : ram[bus.address[8:2]];
        if (bus.write) begin
          if (bus.byteenable != 4'hF) sub_be <= bus.byteenable;
          for (int b = 0; b < 4; b++)
            if (bus.byteenable[b]) ram[bus.address[8:2]][8*b +: 8] <= bus.writedata[8*b +: 8];
        end
      end
    end else begin
      held <= 1'b0;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 32'h0000_0000;
  endtask

  // Reset, release, then wait (bounded) for the program to halt.
  task automatic run_prog(input string tag);
    int cyc;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (active === 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_halt"}, {31'd0, active}, 32'd0);
  endtask

  task automatic load_test(input string tag, input logic [31:0] instr, input logic [31:0] exp);
    clear_rom();
    rom[0] = instr;
    rom[1] = 32'h0000_0008;
    run_prog(tag);
    chk(tag, register_v0, exp);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    for (int i = 0; i < 128; i++) ram_init[i] = 32'h0;
    ram_init[4] = 32'h80FF_7F01;
    clear_rom();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_read", {31'd0, bus.read}, 32'd0);
    chk("rst_write", {31'd0, bus.write}, 32'd0);
    chk("rst_be", {28'd0, bus.byteenable}, 32'hF);
    chk("rst_v0", register_v0, 32'd0);

    // addiu $2,$0,5; jr $0; nop
    rom[0] = 32'h2402_0005; rom[1] = 32'h0000_0008;
    run_prog("basic");
    chk("basic_v0", register_v0, 32'd5);
    repeat (3) @(negedge clk);
    chk("halt_noreq", {30'd0, bus.read, bus.write}, 32'd0);

    // Same program with random stalls
    stall_mode = 1'b1;
    run_prog("stall");
    chk("stall_v0", register_v0, 32'd5);
    chk("stall_seen", {31'd0, stall_seen != 0}, 32'd1);
    chk("stall_stable", stable_err, 32'd0);
    stall_mode = 1'b0;

    // Store word, overwrite byte 1, load word back
    clear_rom();
    rom[0] = 32'h3C03_0000; rom[1] = 32'h2404_FFFE; rom[2] = 32'hAC64_0008;
    rom[3] = 32'hA060_0009; rom[4] = 32'h8C62_0008; rom[5] = 32'h0000_0008;
    run_prog("ldst");
    chk("ldst_v0", register_v0, 32'hFFFF_00FE);
    chk("sb_be", {28'd0, sub_be}, 32'h2);

    // Sub-word loads from 0x80FF7F01 at address 0x10
    load_test("lb0", 32'h8002_0010, 32'h0000_0001);
    load_test("lb1", 32'h8002_0011, 32'h0000_007F);
    load_test("lb2", 32'h8002_0012, 32'hFFFF_FFFF);
    load_test("lb3", 32'h8002_0013, 32'hFFFF_FF80);
    load_test("lbu3", 32'h9002_0013, 32'h0000_0080);
    load_test("lh0", 32'h8402_0010, 32'h0000_7F01);
    load_test("lh2", 32'h8402_0012, 32'hFFFF_80FF);
    load_test("lhu2", 32'h9402_0012, 32'h0000_80FF);
    load_test("lw", 32'h8C02_0010, 32'h80FF_7F01);
    load_test("sltiu", 32'h2C02_FFFF, 32'h0000_0001);

    // Branch delay slot: v0 = 1 + 2, skipped instruction would add 100
    clear_rom();
    rom[0] = 32'h1000_0002; rom[1] = 32'h2402_0001; rom[2] = 32'h2442_0064;
    rom[3] = 32'h2442_0002; rom[4] = 32'h0000_0008;
    run_prog("delay");
    chk("delay_v0", register_v0, 32'd3);

    // JAL to 0xBFC00010, link copied to $2
    clear_rom();
    rom[0] = 32'h0FF0_0004; rom[4] = 32'h03E0_1021; rom[5] = 32'h0000_0008;
    run_prog("jal");
    chk("jal_v0", register_v0, 32'hBFC0_0008);

    // SLT / SLTU of -1 and 1
    clear_rom();
    rom[0] = 32'h2404_FFFF; rom[1] = 32'h2405_0001; rom[2] = 32'h0085_102A; rom[3] = 32'h0000_0008;
    run_prog("slt");
    chk("slt_v0", register_v0, 32'd1);
    rom[2] = 32'h0085_102B;
    run_prog("sltu");
    chk("sltu_v0", register_v0, 32'd0);

    // SRA 0x80000000 by 4
    clear_rom();
    rom[0] = 32'h3C04_8000; rom[1] = 32'h0004_1103; rom[2] = 32'h0000_0008;
    run_prog("sra");
    chk("sra_v0", register_v0, 32'hF800_0000);

    // Write to $0 discarded
    clear_rom();
    rom[0] = 32'h2400_0007; rom[1] = 32'h2402_0009; rom[2] = 32'h0000_0008;
    run_prog("zero");
    chk("zero_v0", register_v0, 32'd9);

    // Reset mid-program: v0=5 then spin on beq-to-self
    clear_rom();
    rom[0] = 32'h2402_0005; rom[1] = 32'h1000_FFFF;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("spin_active", {31'd0, active}, 32'd1);
    chk("spin_v0", register_v0, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_v0", register_v0, 32'd0);
    chk("mid_rst_active", {31'd0, active}, 32'd1);
    chk("mid_rst_req", {30'd0, bus.read, bus.write}, 32'd0);
    reset = 1'b0;
    cyc = 0;
    while (bus.read !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("restart_read", {31'd0, bus.read}, 32'd1);
    chk("restart_addr", bus.address, 32'hBFC0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
